axi_lite_reg_slave: RTL and testbench
=====================================

# axi_lite_reg_slave

AXI-Lite responder exposing `N_REGS` 32-bit read/write control registers to a bus master. It sits behind the interconnect on the slave side of an AXI-Lite link. It drives the register contents and per-register write strobes toward the peripheral logic. Write address and write data are accepted independently, one write and one read outstanding at a time, with OKAY/SLVERR responses.

## Interface
- `DATA_WIDTH`, 32: bus data width; only 32 is supported.
- `ADDR_WIDTH`, 32: bus address width.
- `N_REGS`, 8: number of registers, power of two, 2..256.
- `ACLK` in 1: single clock, all logic rising-edge.
- `ARESET` in 1: reset is synchronous and active-high.
- `AWADDR` in ADDR_WIDTH; `AWVALID` in 1; `AWPROT` in 3 (ignored); `AWREADY` out 1.
- `WDATA` in DATA_WIDTH; `WSTRB` in $clog2(DATA_WIDTH) (bits [3:0] are byte enables, upper bits ignored); `WVALID` in 1; `WREADY` out 1.
- `BRESP` out 2; `BVALID` out 1; `BREADY` in 1.
- `ARADDR` in ADDR_WIDTH; `ARVALID` in 1; `ARREADY` out 1.
- `RDATA` out DATA_WIDTH; `RRESP` out 2; `RVALID` out 1; `RREADY` in 1.
- `regs_o` out N_REGS*DATA_WIDTH: register contents, reg k at bits [32k+31:32k].
- `wr_pulse_o` out N_REGS: one-cycle pulse on the commit cycle of a write to reg k.

## Operation
- Decode: word index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. Index < N_REGS is in range, otherwise out of range. RESP OKAY=2'b00, SLVERR=2'b10.
- Write path: independent holding registers for AW (`aw_held`, addr) and W (`w_held`, data, strobe).
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - When both are held, either from earlier cycles or from handshakes this cycle, the write commits on the next edge.
  - Commit updates the byte lanes with WSTRB[i]=1 of the addressed register and pulses wr_pulse_o[idx].
  - Commit sets BVALID and clears both held flags. BRESP=OKAY in range, SLVERR out of range. Out of range: no register or pulse change.
  - BVALID holds with stable BRESP until BREADY; clears on the BVALID&&BREADY edge.
  - Write states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP. W_IDLE and W_HAVE_* go to W_RESP on commit. W_RESP goes to W_IDLE on B handshake.
- Read path, states R_IDLE and R_DATA:
  - ARREADY = !RVALID.
  - AR handshake latches RDATA, the addressed register or 0 if out of range, plus RRESP OKAY/SLVERR, and sets RVALID.
  - RDATA/RRESP are held stable until the RVALID&&RREADY edge, which clears RVALID.
- Read and write paths are fully independent and may be active in the same cycle.

## Timing
- Reset values: all registers 0, regs_o=0, wr_pulse_o=0, AWREADY=1, WREADY=1, BVALID=0, BRESP=0, ARREADY=1, RVALID=0, RDATA=0, RRESP=0. Held flags cleared, FSMs idle.
- Write with AW and W handshaking together at edge N: register, regs_o and wr_pulse_o update at N+1, with BVALID=1 at N+1. With BREADY=1, BVALID drops at N+2. Back-to-back writes give a B response every 2 cycles.
- AW at edge N and W at edge N+k: commit at edge N+k+1. The mirror order (W first) behaves the same.
- Read: AR at edge N, then RVALID=1 at N+1. With RREADY=1, ARREADY returns at N+2.
- AR and a write commit to the same register on the same edge: the read returns the pre-write value.
- Sustained BREADY=0 or RREADY=0 stalls only that channel. At most one of each AW/W may be held during the stall.
- ARESET mid-transaction: all state returns to reset values on that edge. Pending responses are dropped.

## Structure
- Package `axi_lite_pkg`:
  - resp constants `RESP_OKAY`, `RESP_SLVERR`;
  - enums `wr_state_t`, `rd_state_t`;
  - `ADDR_LSB`=2.
- Single module. No sub-module needed; byte-lane update is an inline loop.

## Test plan
- Reset, then write reg 3 with 0xDEADBEEF, WSTRB=4'hF, AW and W together → BRESP=OKAY one cycle later. A read of addr 0x0C returns 0xDEADBEEF/OKAY. wr_pulse_o[3] pulses once.
- Byte enables: reg 1=0x11223344, then write 0xAABBCCDD with WSTRB=4'b0101 → reads back 0x11BB33DD.
- Ordering: W three cycles before AW, then AW three cycles before W → both commit one cycle after the second handshake. AWREADY/WREADY deassert while the item is held.
- Out of range: write/read addr N_REGS*4 → SLVERR on both. RDATA=0, no register changes, no pulse.
- Backpressure: BREADY=0 and RREADY=0 for 10 cycles → BVALID/RVALID, BRESP/RDATA stay stable. AWREADY/ARREADY stay low until the handshake.
- Assert ARESET while BVALID=1 and RVALID=1 → next cycle all outputs and registers are at reset values. A following write to reg 0 completes normally.

Source files
------------

// File: rtl/axi_lite_reg_slave_pkg.sv
// Shared constants and state encodings for the AXI-Lite register responder.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB    = 2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite responder for N_REGS 32-bit control registers; write commits one edge after AW and W are both seen.
// Read data one edge after AR; B and R stall independently, with AW/W/AR ready low while a response waits.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int N_REGS     = 8
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    input  logic [2:0]                     AWPROT,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [$clog2(DATA_WIDTH)-1:0]  WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [N_REGS*DATA_WIDTH-1:0]   regs_o,
    output logic [N_REGS-1:0]              wr_pulse_o
);

    localparam int IDX_W  = $clog2(N_REGS);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int WORD_W = ADDR_WIDTH - ADDR_LSB;

    wr_state_t                            wr_state_q, wr_state_d;
    logic [WORD_W-1:0]                    awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
    logic [NBYTES-1:0]                    wstrb_q, wstrb_d;
    logic [1:0]                           bresp_q, bresp_d;
    logic [N_REGS-1:0][DATA_WIDTH-1:0]    regs_q, regs_d;
    logic [N_REGS-1:0]                    wr_pulse_q, wr_pulse_d;
    rd_state_t                            rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0]                rdata_q, rdata_d;
    logic [1:0]                           rresp_q, rresp_d;

    logic                    aw_held, w_held, aw_hs, w_hs, commit;
    logic [WORD_W-1:0]       wr_word, rd_word;
    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic                    wr_in_range, rd_in_range, ar_hs;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [NBYTES-1:0]       wr_strb;

    // Protection bits, sub-word address bits and spare strobe bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{AWPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0], WSTRB};

    assign aw_held = (wr_state_q == W_HAVE_ADDR);
    assign w_held  = (wr_state_q == W_HAVE_DATA);
    assign BVALID  = (wr_state_q == W_RESP);
    assign AWREADY = !aw_held && !BVALID;
    assign WREADY  = !w_held && !BVALID;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);

    // Commit operands come from the holding registers if held, otherwise straight off the bus.
    assign wr_word     = aw_held ? awaddr_q : AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign wr_data     = w_held ? wdata_q : WDATA;
    assign wr_strb     = w_held ? wstrb_q : WSTRB[NBYTES-1:0];
    assign wr_idx      = wr_word[IDX_W-1:0];
    assign wr_in_range = (wr_word < WORD_W'(N_REGS));

    assign RVALID      = (rd_state_q == R_DATA);
    assign ARREADY     = !RVALID;
    assign ar_hs       = ARVALID && ARREADY;
    assign rd_word     = ARADDR[ADDR_WIDTH-1:ADDR_LSB];
    assign rd_idx      = rd_word[IDX_W-1:0];
    assign rd_in_range = (rd_word < WORD_W'(N_REGS));

    assign BRESP      = bresp_q;
    assign RDATA      = rdata_q;
    assign RRESP      = rresp_q;
    assign regs_o     = regs_q;
    assign wr_pulse_o = wr_pulse_q;

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        if (aw_hs) begin
            awaddr_d = AWADDR[ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
            wdata_d = WDATA;
            wstrb_d = WSTRB[NBYTES-1:0];
        end

        unique case (wr_state_q)
            W_IDLE: begin
                if (commit)     wr_state_d = W_RESP;
                else if (aw_hs) wr_state_d = W_HAVE_ADDR;
                else if (w_hs)  wr_state_d = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (commit) wr_state_d = W_RESP;
            W_HAVE_DATA: if (commit) wr_state_d = W_RESP;
            W_RESP:      if (BREADY) wr_state_d = W_IDLE;
            default:     wr_state_d = W_IDLE;
        endcase

        if (commit) begin
            bresp_d = wr_in_range ? RESP_OKAY : RESP_SLVERR;
            if (wr_in_range) begin
                wr_pulse_d[wr_idx] = 1'b1;
                for (int b = 0; b < NBYTES; b++) begin
                    if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Reads sample regs_q, so a same-edge write is not yet visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_DATA;
                    rdata_d    = rd_in_range ? regs_q[rd_idx] : '0;
                    rresp_d    = rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA:  if (RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed plus randomized bench for axi_lite_reg_slave against an array-based register model.
module tb_axi_lite_reg_slave;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 8;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [AW-1:0]   AWADDR;
    logic            AWVALID;
    logic [2:0]      AWPROT;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [4:0]      WSTRB;
    logic            WVALID;
    logic            WREADY;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [AW-1:0]   ARADDR;
    logic            ARVALID;
    logic            ARREADY;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RVALID;
    logic            RREADY;
    logic [NR*DW-1:0] regs_o;
    logic [NR-1:0]   wr_pulse_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] mregs [NR];

    axi_lite_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_REGS(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >> 2) < NR;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = mregs[i];
        return v;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] strb);
        int idx;
        if (in_rng(addr)) begin
            idx = int'(addr >> 2);
            for (int b = 0; b < 4; b++)
                if (strb[b]) mregs[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    function automatic logic [NR-1:0] model_pulse(input logic [31:0] addr);
        logic [NR-1:0] p;
        p = '0;
        if (in_rng(addr)) p[int'(addr >> 2)] = 1'b1;
        return p;
    endfunction

    // W is offered from cycle w_dly, AW from cycle aw_dly; B is then stalled for 'stall' cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            input int aw_dly, input int w_dly, input int stall);
        bit aw_done, w_done, aw_fire, w_fire;
        int c;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; c = 0;
        BREADY = 1'b0;
        while (!(aw_done && w_done) && c < 64) begin
            AWADDR  = addr;
            WDATA   = data;
            WSTRB   = strb;
            AWVALID = (c >= aw_dly) && !aw_done;
            WVALID  = (c >= w_dly) && !w_done;
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            tick();
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done = 1;
            if (aw_done && !w_done) begin
                check("awready_held", AWREADY, 0);
                check("bvalid_early_aw", BVALID, 0);
            end
            if (w_done && !aw_done) begin
                check("wready_held", WREADY, 0);
                check("bvalid_early_w", BVALID, 0);
            end
            c++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (!(aw_done && w_done)) check("write_handshake_timeout", 0, 1);
        exp_resp = in_rng(addr) ? 2'b00 : 2'b10;
        check("bvalid_commit", BVALID, 1);
        check("bresp", BRESP, exp_resp);
        check("wr_pulse", wr_pulse_o, model_pulse(addr));
        model_write(addr, data, strb);
        check("regs_after_write", regs_o, model_flat());
        for (int s = 0; s < stall; s++) begin
            tick();
            check("bvalid_stall", BVALID, 1);
            check("bresp_stall", BRESP, exp_resp);
            check("awready_stall", AWREADY, 0);
            check("wready_stall", WREADY, 0);
            check("pulse_once", wr_pulse_o, 0);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_clear", BVALID, 0);
        check("pulse_clear", wr_pulse_o, 0);
        check("awready_back", AWREADY, 1);
        check("wready_back", WREADY, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall);
        logic [31:0] ed;
        logic [1:0]  er;
        ed = in_rng(addr) ? mregs[int'(addr >> 2)] : 32'h0;
        er = in_rng(addr) ? 2'b00 : 2'b10;
        RREADY = 1'b0;
        check("arready_idle", ARREADY, 1);
        ARADDR  = addr;
        ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        check("rvalid", RVALID, 1);
        check("rdata", RDATA, ed);
        check("rresp", RRESP, er);
        check("arready_busy", ARREADY, 0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("rvalid_stall", RVALID, 1);
            check("rdata_stall", RDATA, ed);
            check("rresp_stall", RRESP, er);
            check("arready_stall", ARREADY, 0);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("rvalid_clear", RVALID, 0);
        check("arready_back", ARREADY, 1);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [4:0]  st;
        ARESET = 1'b1;
        AWADDR = '0; AWVALID = 0; AWPROT = '0; WDATA = '0; WSTRB = '0; WVALID = 0;
        BREADY = 0; ARADDR = '0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        tick();
        tick();
        ARESET = 1'b0;

        check("rst_awready", AWREADY, 1);
        check("rst_wready", WREADY, 1);
        check("rst_bvalid", BVALID, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_arready", ARREADY, 1);
        check("rst_rvalid", RVALID, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_regs", regs_o, 0);
        check("rst_pulse", wr_pulse_o, 0);

        do_write(32'h0C, 32'hDEADBEEF, 5'h0F, 0, 0, 0);
        check("reg3_value", regs_o[127:96], 32'hDEADBEEF);
        do_read(32'h0C, 0);

        do_write(32'h04, 32'h11223344, 5'h0F, 0, 0, 0);
        do_write(32'h04, 32'hAABBCCDD, 5'b00101, 0, 0, 0);
        check("byte_merge", regs_o[63:32], 32'h11BB33DD);
        do_read(32'h05, 0);

        do_write(32'h08, 32'h01020304, 5'h0F, 3, 0, 0);
        do_write(32'h10, 32'hCAFEF00D, 5'h0F, 0, 3, 0);
        do_read(32'h08, 0);
        do_read(32'h10, 0);

        do_write(NR * 4, 32'hFFFFFFFF, 5'h0F, 0, 0, 0);
        do_read(NR * 4, 0);

        do_write(32'h18, 32'h5A5A5A5A, 5'h0F, 0, 0, 10);
        do_read(32'h18, 10);

        // Read and write of reg 5 on the same edge: read sees the old value.
        do_write(32'h14, 32'h12345678, 5'h0F, 0, 0, 0);
        AWADDR = 32'h14; WDATA = 32'h87654321; WSTRB = 5'h0F;
        AWVALID = 1; WVALID = 1; ARADDR = 32'h14; ARVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        check("same_edge_rdata", RDATA, 32'h12345678);
        model_write(32'h14, 32'h87654321, 5'h0F);
        check("same_edge_regs", regs_o, model_flat());
        check("same_edge_bvalid", BVALID, 1);
        BREADY = 1; RREADY = 1;
        tick();
        BREADY = 0; RREADY = 0;
        check("same_edge_bclr", BVALID, 0);
        check("same_edge_rclr", RVALID, 0);

        // Reset with both responses pending.
        AWADDR = 32'h08; WDATA = 32'h0BADF00D; WSTRB = 5'h0F;
        AWVALID = 1; WVALID = 1; ARADDR = 32'h08; ARVALID = 1;
        tick();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        check("pend_bvalid", BVALID, 1);
        check("pend_rvalid", RVALID, 1);
        ARESET = 1;
        tick();
        ARESET = 0;
        for (int i = 0; i < NR; i++) mregs[i] = '0;
        check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_bresp", BRESP, 0);
        check("mid_rst_rdata", RDATA, 0);
        check("mid_rst_rresp", RRESP, 0);
        check("mid_rst_awready", AWREADY, 1);
        check("mid_rst_wready", WREADY, 1);
        check("mid_rst_arready", ARREADY, 1);
        check("mid_rst_regs", regs_o, 0);
        check("mid_rst_pulse", wr_pulse_o, 0);
        do_write(32'h00, 32'hA5A5_0001, 5'h0F, 0, 0, 0);
        do_read(32'h00, 0);

        for (int it = 0; it < 40; it++) begin
            a  = ($urandom_range(0, NR + 1) << 2) | $urandom_range(0, 3);
            if (it % 10 == 9) a = 32'hFFFF_FF00 | $urandom_range(0, 255);
            d  = $urandom;
            st = 5'($urandom_range(0, 31));
            do_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            a = ($urandom_range(0, NR + 1) << 2) | $urandom_range(0, 3);
            do_read(a, $urandom_range(0, 2));
        end
        check("final_regs", regs_o, model_flat());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
